// File: rtl/usb_rx_packet_reader.sv
// usb_rx_packet_reader
// Consumes bytes from the USB receiver's show-ahead RX FIFO. It validates and
// classifies the PID byte and streams payload bytes (data + CRC16) downstream
// over a valid/ready handshake, marking the final byte. It also reports PID,
// length and bus errors while draining the rest of a bad packet.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   r_data, empty         FIFO head byte (valid when empty=0) and empty flag
//   rcving, r_error       receiver mid-packet flag and receiver error level
//   r_enable              FIFO pop (combinational, never high when empty=1)
//   pid, pid_valid        last accepted PID and its one-cycle update pulse
//   out_data/valid/ready  payload byte stream; out_last marks the final byte
//   byte_count            payload bytes popped in the current packet
//   pkt_done, pkt_err     one-cycle end-of-packet pulses (clean / error)
//   err_code              01 PID check, 10 length, 11 bus error (held)
module usb_rx_packet_reader #(
    parameter int MAX_BYTES = 66
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] r_data,
    input  logic       empty,
    input  logic       rcving,
    input  logic       r_error,
    output logic       r_enable,
    output logic [3:0] pid,
    output logic       pid_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [6:0] byte_count,
    output logic       pkt_done,
    output logic       pkt_err,
    output logic [1:0] err_code
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        HSHAKE  = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam logic [6:0] MAX_COUNT = 7'(MAX_BYTES);

    // Upper nibble of a PID byte must be the ones-complement of the lower one.
    function automatic logic pid_check_ok(input logic [7:0] b);
        return (b[7:4] == ~b[3:0]);
    endfunction

    // ACK, NAK and STALL carry no payload.
    function automatic logic pid_is_handshake(input logic [3:0] p);
        return (p == 4'h2) || (p == 4'hA) || (p == 4'hE);
    endfunction

    state_t      state_r;
    logic        hold_v_r;
    logic [7:0]  out_data_r;
    logic [3:0]  pid_r;
    logic        pid_valid_r;
    logic [6:0]  byte_count_r;
    logic        pkt_done_r;
    logic        pkt_err_r;
    logic [1:0]  err_code_r;

    logic        eop_s;
    logic        out_valid_s;
    logic        out_last_s;
    logic        accept_s;
    logic        want_pop_s;
    logic        len_full_s;
    logic        r_enable_s;

    // Output handshake, pop request and end-of-packet detection.
    always_comb begin
        eop_s       = ~rcving & empty;
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
        // A bus error suppresses the held byte in the same cycle.
        if ((state_r == PAYLOAD) && !r_error) begin
            out_valid_s = hold_v_r & (~empty | eop_s);
            out_last_s  = hold_v_r & eop_s;
        end else begin
            out_valid_s = 1'b0;
            out_last_s  = 1'b0;
        end
        accept_s   = out_valid_s & out_ready;
        want_pop_s = ~empty & (~hold_v_r | accept_s);
        len_full_s = (byte_count_r >= MAX_COUNT);
        case (state_r)
            IDLE:    r_enable_s = ~empty;
            PAYLOAD: r_enable_s = want_pop_s & ~len_full_s & ~r_error;
            HSHAKE:  r_enable_s = 1'b0;
            DRAIN:   r_enable_s = ~empty;
            default: r_enable_s = 1'b0;
        endcase
    end

    // Packet state machine, hold register and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            hold_v_r     <= 1'b0;
            out_data_r   <= 8'h00;
            pid_r        <= 4'h0;
            pid_valid_r  <= 1'b0;
            byte_count_r <= 7'd0;
            pkt_done_r   <= 1'b0;
            pkt_err_r    <= 1'b0;
            err_code_r   <= 2'b00;
        end else begin
            pid_valid_r <= 1'b0;
            pkt_done_r  <= 1'b0;
            pkt_err_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!empty) begin
                        if (r_error) begin
                            // Byte arriving under a bus error is discarded silently.
                            state_r <= DRAIN;
                        end else if (!pid_check_ok(r_data)) begin
                            pkt_err_r  <= 1'b1;
                            err_code_r <= 2'b01;
                            state_r    <= DRAIN;
                        end else begin
                            pid_r        <= r_data[3:0];
                            pid_valid_r  <= 1'b1;
                            byte_count_r <= 7'd0;
                            hold_v_r     <= 1'b0;
                            state_r      <= pid_is_handshake(r_data[3:0]) ? HSHAKE : PAYLOAD;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PAYLOAD: begin
                    if (r_error) begin
                        pkt_err_r  <= 1'b1;
                        err_code_r <= 2'b11;
                        hold_v_r   <= 1'b0;
                        state_r    <= DRAIN;
                    end else if (accept_s && out_last_s) begin
                        pkt_done_r <= 1'b1;
                        hold_v_r   <= 1'b0;
                        state_r    <= IDLE;
                    end else if (eop_s && !hold_v_r) begin
                        // Zero-byte payload, or final byte already delivered.
                        pkt_done_r <= 1'b1;
                        state_r    <= IDLE;
                    end else if (want_pop_s && len_full_s) begin
                        pkt_err_r  <= 1'b1;
                        err_code_r <= 2'b10;
                        hold_v_r   <= 1'b0;
                        state_r    <= DRAIN;
                    end else if (want_pop_s) begin
                        // Pop and hand-off may coincide: full one-byte-per-cycle rate.
                        out_data_r   <= r_data;
                        hold_v_r     <= 1'b1;
                        byte_count_r <= byte_count_r + 7'd1;
                    end else if (accept_s) begin
                        hold_v_r <= 1'b0;
                    end else begin
                        hold_v_r <= hold_v_r;
                    end
                end
                HSHAKE: begin
                    if (r_error) begin
                        pkt_err_r  <= 1'b1;
                        err_code_r <= 2'b11;
                        state_r    <= DRAIN;
                    end else if (eop_s) begin
                        pkt_done_r <= 1'b1;
                        state_r    <= IDLE;
                    end else if (!empty) begin
                        pkt_err_r  <= 1'b1;
                        err_code_r <= 2'b10;
                        state_r    <= DRAIN;
                    end else begin
                        state_r <= HSHAKE;
                    end
                end
                DRAIN: begin
                    if (eop_s && !r_error) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    hold_v_r <= 1'b0;
                end
            endcase
        end
    end

    assign r_enable   = r_enable_s & ~rst;
    assign pid        = pid_r;
    assign pid_valid  = pid_valid_r;
    assign out_data   = out_data_r;
    assign out_valid  = out_valid_s;
    assign out_last   = out_last_s;
    assign byte_count = byte_count_r;
    assign pkt_done   = pkt_done_r;
    assign pkt_err    = pkt_err_r;
    assign err_code   = err_code_r;

endmodule

// File: tb/tb_usb_rx_packet_reader.sv
// Testbench for usb_rx_packet_reader: a FIFO model feeds packets byte by byte
// while a packet-level reference decides what the packet should produce.
module tb_usb_rx_packet_reader;

    typedef logic [7:0] bq_t[$];
    localparam int MAXB = 66;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] r_data;
    logic       empty;
    logic       rcving;
    logic       r_error;
    logic       r_enable;
    logic [3:0] pid;
    logic       pid_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic [6:0] byte_count;
    logic       pkt_done;
    logic       pkt_err;
    logic [1:0] err_code;

    usb_rx_packet_reader #(.MAX_BYTES(MAXB)) dut (
        .clk(clk), .rst(rst), .r_data(r_data), .empty(empty), .rcving(rcving),
        .r_error(r_error), .r_enable(r_enable), .pid(pid), .pid_valid(pid_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .byte_count(byte_count), .pkt_done(pkt_done),
        .pkt_err(pkt_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // FIFO contents and bytes still to arrive from the wire
    bq_t q;
    bq_t src;
    // stimulus control
    int  pops;
    int  err_trig = -1;
    bit  err_fired;
    int  ready_mode = 0;
    bit  toggle_b = 1'b1;
    // observations
    bq_t beats;
    bit  lasts[$];
    int  n_pv, n_done, n_err, max_bc, bad_ren, bad_stable;
    logic [3:0] seen_pid;
    logic [1:0] seen_code;
    bit  stall_prev;
    logic [7:0] prev_od;
    // scoreboard
    int  checks = 0;
    int  passed = 0;

    // One clock: drive inputs, sample comb outputs, advance, sample registers.
    task automatic step(input int push_prob);
        logic en, ov, ol;
        logic [7:0] od;
        if (src.size() > 0 && $urandom_range(99) < push_prob) q.push_back(src.pop_front());
        rcving  = (src.size() > 0);
        r_error = (err_trig >= 0 && !err_fired && pops == err_trig);
        if (r_error) err_fired = 1'b1;
        empty = (q.size() == 0);
        if (empty) r_data = 8'h00;
        else r_data = q[0];
        case (ready_mode)
            0: out_ready = 1'b1;
            1: begin out_ready = toggle_b; toggle_b = ~toggle_b; end
            default: out_ready = 1'($urandom_range(1));
        endcase
        #1;
        en = r_enable; ov = out_valid; od = out_data; ol = out_last;
        if (en && empty) bad_ren++;
        if (stall_prev && ov && (od !== prev_od)) bad_stable++;
        stall_prev = ov && !out_ready;
        prev_od = od;
        @(posedge clk);
        if (en && q.size() > 0) begin void'(q.pop_front()); pops++; end
        if (ov && out_ready) begin beats.push_back(od); lasts.push_back(ol); end
        @(negedge clk);
        if (pid_valid) begin n_pv++; seen_pid = pid; max_bc = 0; end
        if (pkt_done) n_done++;
        if (pkt_err) begin n_err++; seen_code = err_code; end
        if (int'(byte_count) > max_bc) max_bc = int'(byte_count);
    endtask

    task automatic run_packet(input string name, input logic [7:0] pid_byte, input bq_t pl,
                              input int err_at, input int rmode, input int push_prob);
        bit ok_pid, hs, exact, beats_ok, clean_data;
        int exp_pv, exp_done, exp_err, exp_n, exp_nlast, nlast, guard, exp_bc;
        logic [1:0] exp_code;
        // reference: what the packet must produce, from the protocol rules
        ok_pid = (pid_byte[7:4] == ~pid_byte[3:0]);
        hs = (pid_byte[3:0] inside {4'h2, 4'hA, 4'hE});
        exp_pv = ok_pid ? 1 : 0;
        exp_done = 0; exp_err = 0; exp_code = 2'b00; exp_n = 0; exact = 1'b1;
        exp_nlast = 0; clean_data = 1'b0; exp_bc = 0;
        if (!ok_pid) begin
            exp_err = 1; exp_code = 2'b01;
        end else if (hs) begin
            if (pl.size() == 0) exp_done = 1;
            else begin exp_err = 1; exp_code = 2'b10; end
        end else if (err_at >= 0) begin
            exp_err = 1; exp_code = 2'b11; exp_n = err_at; exact = 1'b0;
        end else if (pl.size() > MAXB) begin
            exp_err = 1; exp_code = 2'b10; exp_n = MAXB; exp_bc = MAXB;
        end else begin
            exp_done = 1; exp_n = pl.size(); exp_nlast = (pl.size() > 0) ? 1 : 0;
            clean_data = 1'b1; exp_bc = pl.size();
        end

        beats.delete(); lasts.delete();
        n_pv = 0; n_done = 0; n_err = 0; max_bc = 0; bad_ren = 0; bad_stable = 0;
        pops = 0; err_fired = 1'b0; ready_mode = rmode;
        err_trig = (err_at >= 0) ? err_at + 1 : -1;
        src.delete();
        src.push_back(pid_byte);
        foreach (pl[i]) src.push_back(pl[i]);
        guard = 0;
        while ((src.size() > 0 || q.size() > 0) && guard < 3000) begin step(push_prob); guard++; end
        while ((n_done + n_err) == 0 && guard < 3000) begin step(push_prob); guard++; end
        repeat (3) step(push_prob);
        err_trig = -1;

        checks++;
        if (guard >= 3000) $display("FAIL %s timeout: cycles=%0d required<3000", name, guard);
        else passed++;
        checks++;
        if (n_pv !== exp_pv) $display("FAIL %s pid_valid count: got %0d want %0d", name, n_pv, exp_pv);
        else passed++;
        if (exp_pv == 1) begin
            checks++;
            if (seen_pid !== pid_byte[3:0]) $display("FAIL %s pid: got %h want %h", name, seen_pid, pid_byte[3:0]);
            else passed++;
        end
        checks++;
        if (n_done !== exp_done) $display("FAIL %s pkt_done count: got %0d want %0d", name, n_done, exp_done);
        else passed++;
        checks++;
        if (n_err !== exp_err) $display("FAIL %s pkt_err count: got %0d want %0d", name, n_err, exp_err);
        else passed++;
        if (exp_err == 1) begin
            checks++;
            if (seen_code !== exp_code || err_code !== exp_code)
                $display("FAIL %s err_code: got %b/%b want %b", name, seen_code, err_code, exp_code);
            else passed++;
        end
        beats_ok = exact ? (beats.size() == exp_n) : (beats.size() <= exp_n);
        foreach (beats[i]) if (i >= pl.size() || beats[i] !== pl[i]) beats_ok = 1'b0;
        checks++;
        if (!beats_ok) $display("FAIL %s beats: got %0d bytes want %0d (exact=%0b) in order", name, beats.size(), exp_n, exact);
        else passed++;
        nlast = 0;
        foreach (lasts[i]) if (lasts[i]) nlast++;
        if (exp_nlast == 1 && (lasts.size() == 0 || !lasts[lasts.size()-1])) nlast = -1;
        checks++;
        if (nlast !== exp_nlast) $display("FAIL %s out_last: got %0d want %0d on final beat", name, nlast, exp_nlast);
        else passed++;
        if (ok_pid && (err_at < 0)) begin
            checks++;
            if (max_bc !== exp_bc || (clean_data && int'(byte_count) !== exp_bc))
                $display("FAIL %s byte_count: got max %0d final %0d want %0d", name, max_bc, byte_count, exp_bc);
            else passed++;
        end
        checks++;
        if (bad_ren !== 0 || bad_stable !== 0)
            $display("FAIL %s protocol: pop-on-empty %0d unstable-data %0d want 0/0", name, bad_ren, bad_stable);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step(0);
        rst = 1'b0;
        step(0);
        checks++;
        if ({pid, pid_valid, out_data, out_valid, out_last, byte_count, pkt_done, pkt_err, err_code, r_enable} !== 29'd0)
            $display("FAIL reset: got pid=%h pv=%b od=%h ov=%b ol=%b bc=%0d done=%b err=%b code=%b ren=%b want all 0",
                     pid, pid_valid, out_data, out_valid, out_last, byte_count, pkt_done, pkt_err, err_code, r_enable);
        else passed++;
    endtask

    task automatic test_data_packet();
        bq_t pl;
        pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'hAA); pl.push_back(8'hBB);
        run_packet("data0", 8'hC3, pl, -1, 0, 100);
        run_packet("data0_toggle", 8'hC3, pl, -1, 1, 100);
        run_packet("data0_slow", 8'hC3, pl, -1, 2, 40);
    endtask

    task automatic test_handshake();
        bq_t pl;
        run_packet("ack", 8'hD2, pl, -1, 0, 100);
        pl.push_back(8'h55);
        run_packet("ack_extra", 8'hD2, pl, -1, 0, 100);
        run_packet("zero_len_data", 8'hC3, pl[0:-1], -1, 0, 100);
    endtask

    task automatic test_bad_pid();
        bq_t pl;
        pl.push_back(8'h01); pl.push_back(8'h02); pl.push_back(8'h03);
        run_packet("bad_pid", 8'hC4, pl, -1, 0, 100);
    endtask

    task automatic test_length();
        bq_t pl;
        for (int i = 0; i < 67; i++) pl.push_back(8'($urandom));
        run_packet("too_long", 8'h4B, pl, -1, 2, 100);
        pl.delete();
        for (int i = 0; i < 66; i++) pl.push_back(8'($urandom));
        run_packet("max_len", 8'h4B, pl, -1, 2, 70);
    endtask

    task automatic test_bus_error();
        bq_t pl;
        for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
        run_packet("bus_err", 8'hC3, pl, 5, 2, 60);
    endtask

    task automatic test_reset_mid();
        bq_t pl;
        err_trig = -1; ready_mode = 0;
        src.delete();
        src.push_back(8'hC3);
        for (int i = 0; i < 8; i++) src.push_back(8'($urandom));
        repeat (6) step(100);
        rst = 1'b1;
        step(100);
        checks++;
        if ({pid, pid_valid, out_data, out_valid, out_last, byte_count, pkt_done, pkt_err, err_code, r_enable} !== 29'd0)
            $display("FAIL reset_mid: got pid=%h pv=%b od=%h ov=%b ol=%b bc=%0d done=%b err=%b code=%b ren=%b want all 0",
                     pid, pid_valid, out_data, out_valid, out_last, byte_count, pkt_done, pkt_err, err_code, r_enable);
        else passed++;
        rst = 1'b0;
        q.delete(); src.delete();
        step(100);
        pl.push_back(8'h5A); pl.push_back(8'hA5); pl.push_back(8'h3C);
        run_packet("after_reset", 8'h4B, pl, -1, 2, 80);
    endtask

    task automatic test_random();
        bq_t pl;
        logic [7:0] pb;
        logic [3:0] lo;
        int len, ea;
        for (int n = 0; n < 30; n++) begin
            lo = 4'($urandom_range(15));
            pb = ($urandom_range(9) < 2) ? 8'($urandom) : {~lo, lo};
            if (pb[3:0] inside {4'h2, 4'hA, 4'hE}) len = ($urandom_range(1) == 1) ? 0 : $urandom_range(1, 3);
            else if ($urandom_range(4) == 0) len = $urandom_range(67, 70);
            else len = $urandom_range(0, 66);
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            ea = -1;
            if ((pb[7:4] == ~pb[3:0]) && !(pb[3:0] inside {4'h2, 4'hA, 4'hE}) &&
                len >= 1 && len <= MAXB && $urandom_range(3) == 0)
                ea = $urandom_range(0, len - 1);
            run_packet($sformatf("rand%0d", n), pb, pl, ea, $urandom_range(2), $urandom_range(30, 100));
        end
    endtask

    initial begin
        rst = 1'b1; r_data = 8'h00; empty = 1'b1; rcving = 1'b0; r_error = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_data_packet();
        test_handshake();
        test_bad_pid();
        test_length();
        test_bus_error();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
